// File: rtl/apb_pkg.sv
// Shared types and address decode for the APB completer register bank.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  // pprot bit that marks a non-secure access when set
  localparam int unsigned APB_NONSEC_BIT = 1;

  typedef struct packed {
    logic [7:0] idx;
    logic       oor;
  } apb_dec_t;

  // Converts a byte address into a register index and flags anything
  // below the base or beyond the last register.
  function automatic apb_dec_t apb_decode(
    input logic [63:0] addr,
    input logic [63:0] base,
    input int unsigned lane_shift,
    input int unsigned num_regs
  );
    logic [63:0] off;
    apb_dec_t    d;
    off   = (addr - base) >> lane_shift;
    d.idx = off[7:0];
    d.oor = (addr < base) || (off >= 64'(num_regs));
    return d;
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// Strobe-masked register array with read-only hardware mux and write pulses.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
  input  logic                           pclk,
  input  logic                           preset_n,
  input  logic                           we,
  input  logic [7:0]                     widx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic [7:0]                     ridx,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Byte-lane writes and the matching one-cycle write pulse
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_pulse <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        wr_pulse[i] <= we && (widx == 8'(i));
        if (we && (widx == 8'(i))) begin
          for (int unsigned b = 0; b < NBYTES; b++) begin
            if (wstrb[b]) regs_q[i][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read mux: read-only registers reflect the hardware input
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ridx == 8'(i)) begin
        rdata = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
  end

  // Flatten the register array onto the output bus
  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

endmodule

// File: rtl/apb_completer_regbank.sv
// APB5 completer: transfer FSM, wait states and error checks over apb_regfile.
module apb_completer_regbank
  import apb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [NUM_REGS-1:0]   SEC_MASK    = '0
) (
  input  logic                           pclk,
  input  logic                           preset_n,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [2:0]                     pprot,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic                           pready,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned           NBYTES     = DATA_WIDTH / 8;
  localparam int unsigned           LANE_SHIFT = $clog2(NBYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NBYTES - 1);
  localparam logic [3:0]            WAIT_MAX   = 4'(WAIT_STATES);

  apb_state_e            state_q, state_cur, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [7:0]            idx_q;
  logic                  wr_q, err_q;
  logic [DATA_WIDTH-1:0] wdata_q, rd_data;
  logic [NBYTES-1:0]     strb_q;
  apb_dec_t              dec;
  logic                  ro_hit, sec_hit, err_setup;
  logic                  complete, commit;
  logic                  unused_prot;

  assign unused_prot = ^{pprot[2], pprot[0]};

  // Decode and classify the request presented during the setup phase
  always_comb begin
    dec     = apb_decode(64'(paddr), 64'(BASE_ADDR), LANE_SHIFT, NUM_REGS);
    ro_hit  = 1'b0;
    sec_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (dec.idx == 8'(i)) begin
        ro_hit  = RO_MASK[i];
        sec_hit = SEC_MASK[i];
      end
    end
    err_setup = ((paddr & ALIGN_MASK) != '0) || dec.oor ||
                (pwrite && ro_hit) ||
                (sec_hit && pprot[APB_NONSEC_BIT]) ||
                (!pwrite && (pstrb != '0));
  end

  // Next-state, wait counter and pready.
  // SETUP is never held in the register: it is recognised combinationally
  // from IDLE while the bus shows a setup phase, so an access phase lines
  // up with ACCESS and back-to-back transfers need no idle cycle.
  always_comb begin
    state_cur = state_q;
    if ((state_q == IDLE) && psel && !penable) state_cur = SETUP;
    state_d  = state_cur;
    wcnt_d   = wcnt_q;
    pready   = (state_q == ACCESS) && (wcnt_q == WAIT_MAX);
    complete = pready && psel && penable;
    case (state_cur)
      IDLE:  state_d = IDLE;
      SETUP: begin
        state_d = ACCESS;
        wcnt_d  = '0;
      end
      ACCESS: begin
        if (!psel || complete) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (!pready) begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and wait counter
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Capture the request and its error verdict at the end of setup
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
    end else if (state_cur == SETUP) begin
      idx_q   <= dec.idx;
      wr_q    <= pwrite;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
      err_q   <= err_setup;
    end
  end

  assign commit  = complete && wr_q && !err_q;
  assign prdata  = (pready && !err_q) ? rd_data : '0;
  assign pslverr = pready && err_q;

  apb_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_regfile (
    .pclk     (pclk),
    .preset_n (preset_n),
    .we       (commit),
    .widx     (idx_q),
    .wdata    (wdata_q),
    .wstrb    (strb_q),
    .ridx     (idx_q),
    .rdata    (rd_data),
    .reg_out  (reg_out),
    .hw_in    (hw_in),
    .wr_pulse (wr_pulse)
  );

endmodule

// File: tb/tb_apb_completer_regbank.sv
// Directed bench: three bank instances with 0, 2 and 3 wait states.
module tb_apb_completer_regbank;

  localparam int unsigned NR   = 16;
  localparam int unsigned DW   = 32;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic          pclk = 1'b0;
  logic          preset_n = 1'b0;
  logic [31:0]   paddr = '0;
  logic [2:0]    pprot = '0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [31:0]   pwdata = '0;
  logic [3:0]    pstrb = '0;
  logic          psel_a [3];
  logic          pready_a [3];
  logic [31:0]   prdata_a [3];
  logic          pslverr_a [3];
  logic [NR*DW-1:0] reg_out_a [3];
  logic [NR-1:0] wr_pulse_a [3];
  logic [NR*DW-1:0] hw_in;

  int unsigned   n_checks = 0;
  int unsigned   n_fail = 0;
  int unsigned   pulses [3] = '{0, 0, 0};
  logic [31:0]   exp_reg [3][NR];

  always #5 pclk = ~pclk;

  apb_completer_regbank #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .BASE_ADDR(32'h1000),
    .WAIT_STATES(0), .RO_MASK(16'h0010), .SEC_MASK(16'h0080)) u_dut_w0 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .pprot(pprot), .psel(psel_a[0]),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready_a[0]),
    .prdata(prdata_a[0]), .pslverr(pslverr_a[0]), .reg_out(reg_out_a[0]), .hw_in(hw_in),
    .wr_pulse(wr_pulse_a[0]));

  apb_completer_regbank #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .BASE_ADDR(32'h1000),
    .WAIT_STATES(2), .RO_MASK(16'h0010), .SEC_MASK(16'h0080)) u_dut_w2 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .pprot(pprot), .psel(psel_a[1]),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready_a[1]),
    .prdata(prdata_a[1]), .pslverr(pslverr_a[1]), .reg_out(reg_out_a[1]), .hw_in(hw_in),
    .wr_pulse(wr_pulse_a[1]));

  apb_completer_regbank #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .BASE_ADDR(32'h1000),
    .WAIT_STATES(3), .RO_MASK(16'h0010), .SEC_MASK(16'h0080)) u_dut_w3 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .pprot(pprot), .psel(psel_a[2]),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready_a[2]),
    .prdata(prdata_a[2]), .pslverr(pslverr_a[2]), .reg_out(reg_out_a[2]), .hw_in(hw_in),
    .wr_pulse(wr_pulse_a[2]));

  // Count cycles in which each instance raises any write pulse
  always @(negedge pclk) begin
    for (int k = 0; k < 3; k++) begin
      if (|wr_pulse_a[k]) pulses[k] <= pulses[k] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] flat(input int k);
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = exp_reg[k][i];
    return f;
  endfunction

  // Full APB transfer on instance k; returns with psel still high so a
  // following call forms a back-to-back transfer.
  task automatic xfer(input int k, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb, input logic [2:0] prot,
                      output logic [31:0] rd, output logic er, output int unsigned cyc);
    logic done;
    done = 1'b0;
    rd   = '0;
    er   = 1'b0;
    for (int j = 0; j < 3; j++) psel_a[j] = (j == k);
    paddr = addr; pwrite = wr; pwdata = wd; pstrb = strb; pprot = prot; penable = 1'b0;
    cyc = 1;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int n = 0; n < 32 && !done; n++) begin
      cyc++;
      @(negedge pclk);
      if (pready_a[k]) begin
        rd   = prdata_a[k];
        er   = pslverr_a[k];
        done = 1'b1;
      end else begin
        check_eq("wait_quiet", {prdata_a[k], pslverr_a[k]}, '0);
      end
      @(posedge pclk); #1;
    end
    if (!done) check_eq("xfer_timeout", {31'b0, done}, 1);
    penable = 1'b0;
  endtask

  task automatic idle();
    for (int j = 0; j < 3; j++) psel_a[j] = 1'b0;
    penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int unsigned cyc;
    int unsigned p0;

    for (int i = 0; i < NR; i++) hw_in[i*DW +: DW] = 32'hC0DE_0000 + i;
    for (int k = 0; k < 3; k++) for (int i = 0; i < NR; i++) exp_reg[k][i] = '0;
    for (int j = 0; j < 3; j++) psel_a[j] = 1'b0;

    // Reset state
    repeat (3) @(posedge pclk);
    #1;
    check_eq("rst_pready", pready_a[0], 0);
    check_eq("rst_prdata", prdata_a[0], 0);
    check_eq("rst_pslverr", pslverr_a[0], 0);
    check_eq("rst_wr_pulse", wr_pulse_a[0], 0);
    check_eq("rst_reg_out", reg_out_a[2], 0);
    preset_n = 1'b1;
    @(posedge pclk); #1;

    // Zero-wait full write then read of reg 2
    xfer(0, 1, BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, 3'b000, rd, er, cyc);
    exp_reg[0][2] = 32'hDEAD_BEEF;
    check_eq("w0_err", er, 0);
    check_eq("w0_cycles", cyc, 2);
    check_eq("w0_pulse", wr_pulse_a[0], 16'h0004);
    check_eq("w0_reg_out", reg_out_a[0], flat(0));
    idle();
    check_eq("w0_pulse_once", wr_pulse_a[0], 16'h0000);
    xfer(0, 0, BASE + 32'h8, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    check_eq("r0_data", rd, 32'hDEAD_BEEF);
    check_eq("r0_err", er, 0);
    check_eq("r0_cycles", cyc, 2);
    idle();

    // Three wait states: full write then byte-strobed write to reg 0
    xfer(2, 1, BASE, 32'hAABB_CCDD, 4'hF, 3'b000, rd, er, cyc);
    check_eq("w3_cycles", cyc, 5);
    xfer(2, 1, BASE, 32'h1122_3344, 4'b0101, 3'b000, rd, er, cyc);
    exp_reg[2][0] = 32'hAA22_CC44;
    check_eq("w3_strb_cycles", cyc, 5);
    check_eq("w3_strb_err", er, 0);
    check_eq("w3_strb_reg_out", reg_out_a[2], flat(2));
    idle();
    xfer(2, 0, BASE, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    check_eq("r3_strb_data", rd, 32'hAA22_CC44);
    idle();

    // Error responses on the zero-wait instance
    xfer(0, 1, BASE + 32'h40, 32'h1234_5678, 4'hF, 3'b000, rd, er, cyc);
    check_eq("e_oor_err", er, 1);
    check_eq("e_oor_rdata", rd, 0);
    check_eq("e_oor_pulse", wr_pulse_a[0], 0);
    idle();
    xfer(0, 0, BASE - 32'h4, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    check_eq("e_below_err", er, 1);
    idle();
    xfer(0, 0, BASE + 32'h2, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    check_eq("e_unalign_err", er, 1);
    check_eq("e_unalign_rdata", rd, 0);
    idle();
    xfer(0, 1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, 3'b000, rd, er, cyc);
    check_eq("e_ro_err", er, 1);
    check_eq("e_ro_pulse", wr_pulse_a[0], 0);
    idle();
    xfer(0, 0, BASE + 32'h10, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    check_eq("ro_hw_data", rd, 32'hC0DE_0004);
    check_eq("ro_hw_err", er, 0);
    idle();
    xfer(0, 1, BASE + 32'h1C, 32'h0000_0099, 4'hF, 3'b010, rd, er, cyc);
    check_eq("e_sec_w_err", er, 1);
    idle();
    xfer(0, 1, BASE + 32'h1C, 32'h0000_0077, 4'hF, 3'b000, rd, er, cyc);
    exp_reg[0][7] = 32'h0000_0077;
    check_eq("sec_w_ok_err", er, 0);
    idle();
    xfer(0, 0, BASE + 32'h1C, 32'h0, 4'h0, 3'b010, rd, er, cyc);
    check_eq("e_sec_r_err", er, 1);
    check_eq("e_sec_r_rdata", rd, 0);
    idle();
    xfer(0, 0, BASE + 32'h8, 32'h0, 4'h3, 3'b000, rd, er, cyc);
    check_eq("e_rd_strb_err", er, 1);
    check_eq("e_rd_strb_rdata", rd, 0);
    idle();
    check_eq("err_reg_out", reg_out_a[0], flat(0));

    // Back-to-back write then read of reg 5
    xfer(0, 1, BASE + 32'h14, 32'h1234_5678, 4'hF, 3'b000, rd, er, cyc);
    exp_reg[0][5] = 32'h1234_5678;
    check_eq("b2b_w_cycles", cyc, 2);
    xfer(0, 0, BASE + 32'h14, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    check_eq("b2b_r_data", rd, 32'h1234_5678);
    check_eq("b2b_r_cycles", cyc, 2);
    idle();

    // Abort on the two-wait instance: psel dropped in the second access cycle
    xfer(1, 1, BASE + 32'h4, 32'h0000_1111, 4'hF, 3'b000, rd, er, cyc);
    exp_reg[1][1] = 32'h0000_1111;
    check_eq("w2_cycles", cyc, 4);
    idle();
    p0 = pulses[1];
    psel_a[1] = 1'b1; paddr = BASE + 32'h4; pwrite = 1'b1; pwdata = 32'h5555_AAAA;
    pstrb = 4'hF; pprot = 3'b000; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check_eq("abort_a1_pready", pready_a[1], 0);
    @(posedge pclk); #1;
    psel_a[1] = 1'b0;
    penable = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check_eq("abort_pulses", pulses[1], p0);
    check_eq("abort_reg_out", reg_out_a[1], flat(1));
    xfer(1, 0, BASE + 32'h4, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    check_eq("abort_rd_data", rd, 32'h0000_1111);
    check_eq("abort_rd_cycles", cyc, 4);
    idle();

    // Reset pulsed in the access cycle of a zero-wait write to reg 3
    psel_a[0] = 1'b1; paddr = BASE + 32'hC; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF;
    pstrb = 4'hF; pprot = 3'b000; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check_eq("mid_pready_before", pready_a[0], 1);
    #1 preset_n = 1'b0;
    #1;
    check_eq("mid_rst_pready", pready_a[0], 0);
    check_eq("mid_rst_pslverr", pslverr_a[0], 0);
    check_eq("mid_rst_reg_out0", reg_out_a[0], 0);
    check_eq("mid_rst_reg_out2", reg_out_a[2], 0);
    for (int k = 0; k < 3; k++) for (int i = 0; i < NR; i++) exp_reg[k][i] = '0;
    psel_a[0] = 1'b0;
    penable = 1'b0;
    @(posedge pclk); #1;
    check_eq("mid_rst_no_write", reg_out_a[0], flat(0));
    preset_n = 1'b1;
    @(posedge pclk); #1;
    xfer(0, 1, BASE + 32'hC, 32'h0BAD_F00D, 4'hF, 3'b000, rd, er, cyc);
    check_eq("post_rst_w_err", er, 0);
    check_eq("post_rst_w_cycles", cyc, 2);
    xfer(0, 0, BASE + 32'hC, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    check_eq("post_rst_r_data", rd, 32'h0BAD_F00D);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
